line_clear_ctrl: RTL and testbench
==================================

// Module: line_clear_ctrl
// PURPOSE
//   Sequences the board memory to remove completed rows after a piece locks.
//   gamelogic pulses start from S_CLEAR. The block gains the board port through a
//   req/gnt handshake, then makes one bottom-to-top compaction pass:
//   - full rows are dropped;
//   - kept rows are copied down;
//   - vacated top rows are zero-filled.
//   It reports the number of rows cleared and returns the port.
// PARAMETERS
//   COLS  10  board width in cells
//   ROWS  20  board height in cells
//   XW    4   column address width
//   YW    5   row address width; also the width of lines_cleared
// PORTS
//   CLOCK_50       in   1   system clock; every register updates on the rising edge
//   resetn         in   1   synchronous, active-low reset
//   start          in   1   1-cycle request to run a clear pass
//   busy           out  1   high from the cycle after an accepted start until done
//   done           out  1   1-cycle pulse; the pass is complete
//   lines_cleared  out  YW  count of full rows removed; valid when done is high and held until the next start
//   mem_req        out  1   requests the board port; high whenever busy
//   mem_gnt        in   1   port granted this cycle; may drop at any time
//   board_rx       out  XW  read column address
//   board_ry       out  YW  read row address
//   board_rdata    in   1   cell occupancy, valid 1 cycle after an address issued with mem_gnt=1
//   board_we       out  1   write enable
//   board_wx       out  XW  write column
//   board_wy       out  YW  write row
//   board_wdata    out  1   write data
// BEHAVIOUR
//   Reset values: every output is 0, the FSM is IDLE, and all counters and row_buf are 0.
//   Reset mid-pass:
//   - The block returns to IDLE on the next edge.
//   - board_we drops in that same cycle.
//   - Partial board writes are not undone.
//   Registers:
//   - src: next row to read, counts down from ROWS-1.
//   - dst: next row to write, counts down from ROWS-1.
//   - x: column counter, 0..COLS-1.
//   - row_buf[COLS]: holds the row just read.
//   - cnt: rows cleared so far.
//   Access rule:
//   - An access (read issue or write) occurs only in a cycle with mem_gnt=1.
//   - While mem_gnt=0: board_we=0, and x, src and dst hold.
//   - board_we is combinational from state, counters and mem_gnt.
//   - Data for a read issued with gnt=1 is captured on the next cycle regardless of gnt in that cycle.
//   FSM states:
//   - IDLE
//     - start=1: src<=ROWS-1, dst<=ROWS-1, cnt<=0, busy<=1, go to READ.
//     - start=1 while busy=1 is ignored.
//   - READ
//     - Drive board_rx=x, board_ry=src.
//     - On each granted issue, x increments.
//     - row_buf[x-1] captures board_rdata one cycle after its issue.
//     - After column COLS-1 is issued, go to RTAIL.
//   - RTAIL: capture the last cell, then go to EVAL.
//   - EVAL: evaluate the row in row_buf.
//     - Row full (all 1): cnt<=cnt+1; dst unchanged.
//     - Else if dst==src: nothing to move; dst<=dst-1.
//     - Else: go to WRITE.
//     - If src==0, the next state is FILL when dst has not wrapped below 0, otherwise DONE.
//     - Otherwise src<=src-1, x<=0, back to READ.
//   - WRITE
//     - Write row_buf[x] to (x, dst), x=0..COLS-1.
//     - After the last column: dst<=dst-1; continue exactly as EVAL's src handling.
//   - FILL
//     - Write 0 to every column of rows dst down to 0, in that order.
//     - Then go to DONE.
//     - FILL is skipped entirely when cnt==0.
//   - DONE
//     - done=1 for 1 cycle; lines_cleared<=cnt; busy<=0; mem_req<=0.
//     - Go to IDLE.
//   Timing and arithmetic:
//   - dst is tracked YW+1 bits signed so the last decrement from 0 is detectable.
//   - No-clear pass with gnt tied 1: ROWS*(COLS+2)+2 cycles from start to done, with zero writes.
//   - Rows never moved are never rewritten.
//   - Each moved or filled row costs COLS write cycles.
//   - cnt saturates at ROWS (full board).
// TESTING
//   1. Empty board, gnt=1, start pulse -> done at cycle 242; lines_cleared=0; board_we never high.
//   2. Row 19 full, cell (3,18) set -> lines_cleared=1; only (3,19) set; row 0 all zero.
//   3. Rows 16-19 full, (0,15) set -> lines_cleared=4; only (0,19) set; rows 0-3 zero.
//   4. Rows 17 and 19 full, row 18 = 1010101010 -> lines_cleared=2; row 19 = 1010101010; rows 0-18 zero.
//   5. Case 2 with mem_gnt toggling every cycle -> identical final board; board_we=0 whenever gnt=0.
//   6. resetn low during WRITE -> next cycle busy=0, board_we=0, mem_req=0; start while busy is ignored.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: after a piece locks, compacts the board bottom-to-top in one pass.
// Full rows are dropped, kept rows are copied down, and freed top rows are zero-filled.
module line_clear_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int XW   = 4,
    parameter int YW   = 5
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [YW-1:0] lines_cleared,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [XW-1:0] board_rx,
    output logic [YW-1:0] board_ry,
    input  logic          board_rdata,
    output logic          board_we,
    output logic [XW-1:0] board_wx,
    output logic [YW-1:0] board_wy,
    output logic          board_wdata
);

    typedef enum logic [2:0] {IDLE, READ, RTAIL, EVAL, WRITE, FILL, DONE} state_t;

    state_t                state, state_nxt;
    logic [XW-1:0]         x, x_nxt, rd_idx;
    logic [YW-1:0]         src, src_nxt, cnt, cnt_nxt, cnt_after;
    logic signed [YW:0]    dst, dst_nxt, dst_after;
    logic [COLS-1:0]       row_buf;
    logic                  rd_pend, advance, last_col, dst_is_src;

    assign last_col   = (x == XW'(COLS-1));
    assign dst_is_src = !dst[YW] && (dst[YW-1:0] == src);

    assign mem_req     = busy;
    assign board_rx    = x;
    assign board_ry    = src;
    assign board_wx    = x;
    assign board_wy    = dst[YW-1:0];
    assign board_wdata = (state == WRITE) ? row_buf[x] : 1'b0;
    // Gated by resetn so a reset mid-write stops writing in the very cycle it is asserted.
    assign board_we    = resetn && mem_gnt && (state == WRITE || state == FILL);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        src_nxt   = src;
        dst_nxt   = dst;
        cnt_nxt   = cnt;
        cnt_after = cnt;
        dst_after = dst;
        advance   = 1'b0;
        case (state)
            IDLE: if (start) begin
                src_nxt   = YW'(ROWS-1);
                dst_nxt   = $signed((YW+1)'(ROWS-1));
                cnt_nxt   = '0;
                x_nxt     = '0;
                state_nxt = READ;
            end
            READ: if (mem_gnt) begin
                if (last_col) begin
                    x_nxt     = '0;
                    state_nxt = RTAIL;
                end else begin
                    x_nxt = x + XW'(1);
                end
            end
            RTAIL: state_nxt = EVAL;
            EVAL: begin
                if (&row_buf) begin
                    cnt_after = (cnt == YW'(ROWS)) ? cnt : cnt + YW'(1);
                    cnt_nxt   = cnt_after;
                    advance   = 1'b1;
                end else if (dst_is_src) begin
                    dst_after = dst - $signed((YW+1)'(1));
                    dst_nxt   = dst_after;
                    advance   = 1'b1;
                end else begin
                    x_nxt     = '0;
                    state_nxt = WRITE;
                end
            end
            WRITE: if (mem_gnt) begin
                if (last_col) begin
                    x_nxt     = '0;
                    dst_after = dst - $signed((YW+1)'(1));
                    dst_nxt   = dst_after;
                    advance   = 1'b1;
                end else begin
                    x_nxt = x + XW'(1);
                end
            end
            FILL: if (mem_gnt) begin
                if (last_col) begin
                    x_nxt   = '0;
                    dst_nxt = dst - $signed((YW+1)'(1));
                    if (dst == '0) state_nxt = DONE;
                end else begin
                    x_nxt = x + XW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Row finished: step to the next source row, or wrap up after row 0.
        if (advance) begin
            if (src == '0) begin
                state_nxt = (!dst_after[YW] && cnt_after != '0) ? FILL : DONE;
            end else begin
                src_nxt   = src - YW'(1);
                x_nxt     = '0;
                state_nxt = READ;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            x             <= '0;
            src           <= '0;
            dst           <= '0;
            cnt           <= '0;
            rd_idx        <= '0;
            rd_pend       <= 1'b0;
            row_buf       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            x       <= x_nxt;
            src     <= src_nxt;
            dst     <= dst_nxt;
            cnt     <= cnt_nxt;
            rd_pend <= (state == READ) && mem_gnt;
            rd_idx  <= x;
            if (rd_pend) row_buf[rd_idx] <= board_rdata;
            done    <= (state == DONE);
            if (state == DONE) lines_cleared <= cnt;
            if (state == IDLE && start) busy <= 1'b1;
            else if (state == DONE)     busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: behavioural board RAM, hand-computed final boards,
// cycle count, grant throttling and mid-pass reset.
module tb_line_clear_ctrl;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b0;
    logic          start    = 1'b0;
    logic          mem_gnt  = 1'b1;
    logic          board_rdata = 1'b0;
    logic          busy, done, mem_req, board_we, board_wdata;
    logic [YW-1:0] lines_cleared, board_ry, board_wy;
    logic [XW-1:0] board_rx, board_wx;

    int total = 0;
    int bad   = 0;

    line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy),
        .board_wdata(board_wdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Board RAM: bit x of a row word is column x.
    logic [COLS-1:0] board     [ROWS];
    logic [COLS-1:0] init_rows [ROWS];
    logic [COLS-1:0] exp_rows  [ROWS];
    logic            ld = 1'b0;
    int              we_cnt = 0;
    int              we_bad = 0;

    always @(posedge CLOCK_50) begin
        board_rdata <= board[board_ry][board_rx];
        if (ld) begin
            for (int r = 0; r < ROWS; r++) board[r] <= init_rows[r];
        end else if (board_we) begin
            board[board_wy][board_wx] <= board_wdata;
        end
        if (board_we) we_cnt <= we_cnt + 1;
        if (board_we && !mem_gnt) we_bad <= we_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic clear_init;
        for (int r = 0; r < ROWS; r++) begin
            init_rows[r] = '0;
            exp_rows[r]  = '0;
        end
    endtask

    task automatic do_load;
        @(negedge CLOCK_50); ld = 1'b1;
        @(negedge CLOCK_50); ld = 1'b0;
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s_row%0d", tag, r), 32'(board[r]), 32'(exp_rows[r]));
    endtask

    // Start a pass, count posedges (including the one that samples start) until done.
    task automatic run_pass(input bit toggle, input int extra_at, output int cyc);
        bit fin;
        fin = 1'b0;
        cyc = 0;
        @(negedge CLOCK_50); start = 1'b1; mem_gnt = 1'b1;
        while (!fin) begin
            @(posedge CLOCK_50); cyc++; #1;
            if (done) fin = 1'b1;
            else if (cyc > 4000) begin
                check("done_timeout", 32'(cyc), 32'd0);
                fin = 1'b1;
            end else begin
                @(negedge CLOCK_50);
                start = (cyc == extra_at);
                if (toggle) mem_gnt = ~mem_gnt;
            end
        end
        start   = 1'b0;
        mem_gnt = 1'b1;
    endtask

    initial begin
        int cyc, w0, b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req",  32'(mem_req), 32'd0);
        check("rst_we",   32'(board_we), 32'd0);
        check("rst_lc",   32'(lines_cleared), 32'd0);
        check("rst_ry",   32'(board_ry), 32'd0);
        @(negedge CLOCK_50); resetn = 1'b1;

        // 1: empty board, no clears, no writes
        clear_init(); do_load();
        w0 = we_cnt;
        run_pass(1'b0, -1, cyc);
        check("t1_cycles", 32'(cyc), 32'd242);
        check("t1_lc",     32'(lines_cleared), 32'd0);
        check("t1_busy",   32'(busy), 32'd0);
        check("t1_writes", 32'(we_cnt - w0), 32'd0);
        @(posedge CLOCK_50); #1;
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: bottom row full, one cell above it drops down
        clear_init();
        init_rows[19] = '1; init_rows[18] = 10'b0000001000;
        exp_rows[19]  = 10'b0000001000;
        do_load();
        run_pass(1'b0, -1, cyc);
        check("t2_lc", 32'(lines_cleared), 32'd1);
        check_board("t2");

        // 3: four full rows
        clear_init();
        for (int r = 16; r < 20; r++) init_rows[r] = '1;
        init_rows[15] = 10'b0000000001;
        exp_rows[19]  = 10'b0000000001;
        do_load();
        run_pass(1'b0, -1, cyc);
        check("t3_lc", 32'(lines_cleared), 32'd4);
        check_board("t3");

        // 4: non-adjacent full rows around a partial row
        clear_init();
        init_rows[19] = '1; init_rows[17] = '1;
        init_rows[18] = 10'b1010101010;
        exp_rows[19]  = 10'b1010101010;
        do_load();
        run_pass(1'b0, -1, cyc);
        check("t4_lc", 32'(lines_cleared), 32'd2);
        check_board("t4");
        @(posedge CLOCK_50); #1;
        check("t4_lc_held", 32'(lines_cleared), 32'd2);
        check("t4_done_low", 32'(done), 32'd0);

        // 5: case 2 with grant toggling every cycle
        clear_init();
        init_rows[19] = '1; init_rows[18] = 10'b0000001000;
        exp_rows[19]  = 10'b0000001000;
        do_load();
        b0 = we_bad;
        run_pass(1'b1, -1, cyc);
        check("t5_lc", 32'(lines_cleared), 32'd1);
        check("t5_we_no_gnt", 32'(we_bad - b0), 32'd0);
        check("t5_slower", 32'(cyc > 242), 32'd1);
        check_board("t5");

        // 6: reset while writing, then start-while-busy is ignored
        clear_init();
        init_rows[19] = '1; init_rows[18] = 10'b0000001000;
        do_load();
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        for (int i = 0; i < 1000 && !board_we; i++) @(negedge CLOCK_50);
        check("t6_we_seen", 32'(board_we), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_we_same_cycle", 32'(board_we), 32'd0);
        @(posedge CLOCK_50); #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_we",   32'(board_we), 32'd0);
        check("t6_req",  32'(mem_req), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        @(negedge CLOCK_50); resetn = 1'b1;

        clear_init(); do_load();
        run_pass(1'b0, 50, cyc);
        check("t6_restart_ignored", 32'(cyc), 32'd242);
        check("t6_lc", 32'(lines_cleared), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
